// File: rtl/alu_pkg.sv
// alu_pkg: opcode codes, default widths and flag layout shared by the ALU and its arbiter
package alu_pkg;
    localparam int DEF_WORDSIZE = 32;
    localparam int DEF_OPSIZE   = 4;
    localparam logic [3:0] NOP = 4'd0;
    localparam logic [3:0] ADD = 4'd1;
    localparam logic [3:0] SUB = 4'd2;
    localparam logic [3:0] SLL = 4'd3;
    localparam logic [3:0] SRL = 4'd4;
    localparam logic [3:0] SRA = 4'd5;
    localparam logic [3:0] SLU = 4'd6;
    localparam logic [3:0] SLT = 4'd7;
    localparam logic [3:0] OR  = 4'd8;
    localparam logic [3:0] AND = 4'd9;
    localparam logic [3:0] XOR = 4'd10;
    localparam logic [3:0] SIU = 4'd11;
    localparam logic [3:0] AIU = 4'd12;
    localparam logic [3:0] JLX = 4'd13;
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    function automatic logic [3:0] pack_flags(input logic v, input logic n, input logic z, input logic c);
        logic [3:0] f;
        f = '0;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        return f;
    endfunction
endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant; last_grant moves only on an accepted grant
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant = &eligible ? (last_grant_q ? 2'b01 : 2'b10) : eligible;
        last_grant_d = accept ? grant[1] : last_grant_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with per-port response slots
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int OPSIZE   = DEF_OPSIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WORDSIZE-1:0] req0_a,
    input  logic [WORDSIZE-1:0] req0_b,
    input  logic [OPSIZE-1:0]   req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WORDSIZE-1:0] req1_a,
    input  logic [WORDSIZE-1:0] req1_b,
    input  logic [OPSIZE-1:0]   req1_op,
    output logic [WORDSIZE-1:0] alu_a,
    output logic [WORDSIZE-1:0] alu_b,
    output logic [OPSIZE-1:0]   alu_op,
    input  logic [WORDSIZE-1:0] alu_r,
    input  logic                alu_v,
    input  logic                alu_n,
    input  logic                alu_z,
    input  logic                alu_c,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [WORDSIZE-1:0] rsp0_r,
    output logic [3:0]          rsp0_flags,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [WORDSIZE-1:0] rsp1_r,
    output logic [3:0]          rsp1_flags
);
    logic [1:0]          eligible, grant, rsp_valid_q, rsp_valid_d;
    logic [WORDSIZE-1:0] rsp0_r_q, rsp0_r_d, rsp1_r_q, rsp1_r_d;
    logic [3:0]          rsp0_flags_q, rsp0_flags_d, rsp1_flags_q, rsp1_flags_d, alu_flags;

    // a slot being drained this cycle can take a new result without a bubble
    assign eligible = {req1_valid & (~rsp_valid_q[1] | rsp1_ready),
                       req0_valid & (~rsp_valid_q[0] | rsp0_ready)} & {2{rst_n}};

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .accept   (|grant),
        .grant    (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign alu_a  = grant[0] ? req0_a  : grant[1] ? req1_a  : '0;
    assign alu_b  = grant[0] ? req0_b  : grant[1] ? req1_b  : '0;
    assign alu_op = grant[0] ? req0_op : grant[1] ? req1_op : '0;
    assign alu_flags = pack_flags(alu_v, alu_n, alu_z, alu_c);

    always_comb begin
        rsp_valid_d  = grant | (rsp_valid_q & ~{rsp1_ready, rsp0_ready});
        rsp0_r_d     = grant[0] ? alu_r : rsp0_r_q;
        rsp1_r_d     = grant[1] ? alu_r : rsp1_r_q;
        rsp0_flags_d = grant[0] ? alu_flags : rsp0_flags_q;
        rsp1_flags_d = grant[1] ? alu_flags : rsp1_flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= '0;
            rsp0_r_q     <= '0;
            rsp1_r_q     <= '0;
            rsp0_flags_q <= '0;
            rsp1_flags_q <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp0_r_q     <= rsp0_r_d;
            rsp1_r_q     <= rsp1_r_d;
            rsp0_flags_q <= rsp0_flags_d;
            rsp1_flags_q <= rsp1_flags_d;
        end
    end

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_r     = rsp0_r_q;
    assign rsp1_r     = rsp1_r_q;
    assign rsp0_flags = rsp0_flags_q;
    assign rsp1_flags = rsp1_flags_q;
endmodule
